// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader. Holds the loader state encoding, the length-header
//               width and small state-decode helpers used for the registered
//               outputs.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // The length header is two bytes, little-endian, counting 32-bit words.
    localparam int c_HDR_W = 16;

    // Bytes per assembled instruction word.
    localparam int c_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        CHECK  = 3'd3,
        DATA   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    // The loader only offers to take a byte while parsing the header or
    // collecting word data; every other state leaves the stream pending.
    function automatic logic takes_bytes(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA);
    endfunction

    // A load is in progress from the first header byte until the last write.
    function automatic logic is_busy(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == CHECK) ||
               (s == DATA)   || (s == WRITE);
    endfunction

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time writer for the instruction memory. Accepts a byte
//               stream over a valid/ready handshake, parses a 16-bit
//               little-endian word-count header, assembles little-endian
//               32-bit words and issues one single-cycle write per word.
//               The core is held (cpu_hold) for the whole load so it only
//               ever fetches a complete image.
//
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               start     - one-cycle request to begin a load
//               rx_data   - byte from the UART receiver
//               rx_valid  - rx_data is valid
//               rx_ready  - loader accepts a byte this cycle
//               mem_we    - instruction memory write enable (one cycle/word)
//               mem_addr  - word address of the write
//               mem_wdata - word to write
//               cpu_hold  - keeps the core stalled while loading
//               busy      - load in progress
//               done      - last load completed (level)
//               err       - last load rejected, header exceeded DEPTH (level)
//
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_HDR_W-1:0]  r_n_words;
    logic [c_HDR_W-1:0]  r_word_cnt;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_word_buf;

    // Registered outputs
    logic                r_rx_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // Next-state values
    state_t              w_state;
    logic [c_HDR_W-1:0]  w_n_words;
    logic [c_HDR_W-1:0]  w_word_cnt;
    logic [1:0]          w_byte_cnt;
    logic [31:0]         w_word_buf;
    logic                w_accept;
    logic                w_last_word;
    logic                w_too_long;

    // A byte moves only when both sides agree in the same cycle.
    assign w_accept    = rx_valid && r_rx_ready;
    assign w_last_word = (r_word_cnt == (r_n_words - c_HDR_W'(1)));
    assign w_too_long  = (int'(r_n_words) > DEPTH);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state    = r_state;
        w_n_words  = r_n_words;
        w_word_cnt = r_word_cnt;
        w_byte_cnt = r_byte_cnt;
        w_word_buf = r_word_buf;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state = HDR_LO;
                end
            end

            HDR_LO: begin
                if (w_accept) begin
                    w_n_words[7:0] = rx_data;
                    w_state        = HDR_HI;
                end
            end

            HDR_HI: begin
                if (w_accept) begin
                    w_n_words[15:8] = rx_data;
                    w_state         = CHECK;
                end
            end

            CHECK: begin
                if (r_n_words == '0) begin
                    w_state = DONE;
                end else if (w_too_long) begin
                    w_state = ERR;
                end else begin
                    w_word_cnt = '0;
                    w_byte_cnt = '0;
                    w_state    = DATA;
                end
            end

            DATA: begin
                if (w_accept) begin
                    // First byte of a word lands in bits 7:0.
                    w_word_buf[{r_byte_cnt, 3'b000} +: 8] = rx_data;
                    if (r_byte_cnt == 2'd3) begin
                        w_state = WRITE;
                    end else begin
                        w_byte_cnt = r_byte_cnt + 2'd1;
                    end
                end
            end

            WRITE: begin
                if (w_last_word) begin
                    w_state = DONE;
                end else begin
                    w_word_cnt = r_word_cnt + c_HDR_W'(1);
                    w_byte_cnt = '0;
                    w_state    = DATA;
                end
            end

            DONE, ERR: begin
                if (start) begin
                    w_state = HDR_LO;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and registered outputs. Outputs are decoded from the
    // next state so they line up with the state they describe without an
    // extra cycle of lag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_n_words   <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_word_buf  <= '0;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_n_words  <= w_n_words;
            r_word_cnt <= w_word_cnt;
            r_byte_cnt <= w_byte_cnt;
            r_word_buf <= w_word_buf;

            r_rx_ready <= takes_bytes(w_state);
            r_mem_we   <= (w_state == WRITE);
            r_busy     <= is_busy(w_state);
            r_done     <= (w_state == DONE);
            r_err      <= (w_state == ERR);

            // Address/data are only refreshed on entry to WRITE and hold
            // their last value otherwise; mem_we qualifies them.
            if (w_state == WRITE) begin
                r_mem_addr  <= w_word_cnt[ADDR_W-1:0];
                r_mem_wdata <= w_word_buf;
            end
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign cpu_hold  = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected writes are
//               queued as stimulus is driven and compared against the writes
//               observed on the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // {addr, data} of each write
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];
    int          ready_in_write = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            obs_q.push_back({mem_addr, mem_wdata});
            if (rx_ready) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err});
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents a byte and returns right after the edge that accepts it.
    // rx_valid stays high afterwards so back-to-back calls stream continuously.
    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check("byte_accept_timeout", 64'(rx_ready), 64'd1);
        else @(posedge clk);
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!(done || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!(done || err)) check(tag, 64'({done, err}), 64'b10);
    endtask

    function automatic logic [31:0] gen_word(input int i, input logic [31:0] seed);
        return seed ^ (32'(i) * 32'h0102_0305) ^ {8'(i), 8'(~i), 8'(i + 7), 8'(i * 3)};
    endfunction

    task automatic load(input int n, input logic [31:0] seed);
        logic [31:0] w;
        pulse_start();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = gen_word(i, seed);
            exp_q.push_back({8'(i), w});
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        end
        idle_rx();
    endtask

    task automatic compare_writes(input string tag);
        logic [39:0] e;
        logic [39:0] o;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_write"}, 64'(o), 64'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int t;
        logic any_ready;

        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;

        // Idle for 10 cycles: nothing moves.
        repeat (10) @(negedge clk);
        check("idle_outputs", all_outputs(), 64'd0);
        check("idle_no_write", 64'(obs_q.size()), 64'd0);

        // Two-word load with gaps between bytes.
        pulse_start();
        check("hold_during_load", 64'({cpu_hold, busy}), 64'b11);
        send_byte(8'h02); idle_rx();
        send_byte(8'h00); idle_rx();
        exp_q.push_back({8'd0, 32'h0000_0013});
        exp_q.push_back({8'd1, 32'h0010_0093});
        send_byte(8'h13); idle_rx();
        send_byte(8'h00); idle_rx();
        send_byte(8'h00); idle_rx();
        send_byte(8'h00);
        #1;
        check("we_latency", 64'({mem_we, mem_addr, mem_wdata}), {23'd0, 1'b1, 8'd0, 32'h0000_0013});
        idle_rx();
        send_byte(8'h93); idle_rx();
        send_byte(8'h00); idle_rx();
        send_byte(8'h10); idle_rx();
        send_byte(8'h00); idle_rx();
        wait_end("two_word_end_timeout");
        check("two_word_status", 64'({done, err, cpu_hold, busy}), 64'b1000);
        compare_writes("two_word");

        // Bytes offered after DONE are left alone.
        @(negedge clk);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        any_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_ready |= rx_ready;
        end
        rx_valid = 1'b0;
        check("after_done_not_ready", 64'({any_ready, done}), 64'b01);

        // Zero-length header.
        pulse_start();
        check("start_clears_done", 64'(done), 64'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        idle_rx();
        t = 0;
        while (!done && t < 2) begin
            @(negedge clk);
            t++;
        end
        check("zero_len_done", 64'({done, err}), 64'b10);
        check("zero_len_no_write", 64'(obs_q.size()), 64'd0);

        // Oversized header (257 words).
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        wait_end("oversize_end_timeout");
        check("oversize_err", 64'({err, done, busy}), 64'b100);
        any_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            any_ready |= rx_ready;
        end
        idle_rx();
        check("oversize_not_ready", 64'(any_ready), 64'd0);
        check("oversize_no_write", 64'(obs_q.size()), 64'd0);

        // Recovery from ERR with a one-word load.
        load(1, 32'hDEAD_BEEF);
        check("recover_clears_err", 64'(err), 64'd0);
        wait_end("recover_end_timeout");
        check("recover_status", 64'({done, err}), 64'b10);
        compare_writes("recover");

        // Three words streamed with rx_valid held high throughout.
        ready_in_write = 0;
        load(3, 32'h1234_5678);
        wait_end("stream_end_timeout");
        check("stream_done", 64'(done), 64'd1);
        check("stream_ready_in_write", 64'(ready_in_write), 64'd0);
        compare_writes("stream");

        // Reset in the middle of the data phase.
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_no_write", 64'(obs_q.size()), 64'd0);
        check("mid_reset_idle", all_outputs(), 64'd0);
        load(2, 32'h0BAD_F00D);
        wait_end("post_reset_end_timeout");
        check("post_reset_done", 64'(done), 64'd1);
        compare_writes("post_reset");

        // Full-depth image: every address, no wrap.
        load(DEPTH, 32'hC0DE_0000);
        wait_end("full_end_timeout");
        check("full_status", 64'({done, err, cpu_hold}), 64'b100);
        compare_writes("full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It takes a byte stream from the UART receiver over a valid/ready handshake and parses a length header. It assembles little-endian 32-bit words and issues single-cycle word writes into the instruction memory's write port. While it runs, it holds the RV32I core in stall/reset through cpu_hold, so the core's fetch path only reads a fully written image.

Parameters:
DEPTH, 256, instruction memory depth in 32-bit words.
ADDR_W, 8, word-address width; must equal clog2(DEPTH).

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a load.
rx_data  input  8  byte from the UART receiver.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction memory write enable, one cycle per word.
mem_addr  output  ADDR_W  word address of the write.
mem_wdata  output  32  word to write.
cpu_hold  output  1  keeps the core stalled/reset while the loader is active.
busy  output  1  load in progress.
done  output  1  last load completed successfully (level).
err  output  1  last load rejected because the header exceeded DEPTH (level).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; counters cleared.
  - rx_ready, mem_we, cpu_hold, busy, done, err all 0.
  - mem_addr=0, mem_wdata=0.
  - rst asserted mid-load aborts immediately; no further writes; memory contents already written are left as they are.
- Handshake: a byte is accepted only in a cycle where rx_valid and rx_ready are both 1. rx_ready is a registered function of state: it is 1 only in HDR_LO, HDR_HI and DATA.
- States and transitions:
  - IDLE: on start, go to HDR_LO and clear done and err. start is ignored in every other state except DONE and ERR.
  - HDR_LO: on an accepted byte, n_words[7:0] = byte; go to HDR_HI.
  - HDR_HI: on an accepted byte, n_words[15:8] = byte; go to CHECK.
  - CHECK (1 cycle):
    - n_words==0: go to DONE.
    - n_words>DEPTH: go to ERR.
    - otherwise: go to DATA with word_cnt=0 and byte_cnt=0.
  - DATA: on an accepted byte, write it into word_buf[8*byte_cnt+:8] (first byte = bits 7:0). When byte_cnt==3, go to WRITE; otherwise increment byte_cnt.
  - WRITE (1 cycle):
    - Outputs: mem_we=1, mem_addr=word_cnt[ADDR_W-1:0], mem_wdata=word_buf.
    - If word_cnt==n_words-1, go to DONE.
    - Otherwise increment word_cnt, clear byte_cnt, and go to DATA.
  - DONE: done=1. On start, go to HDR_LO and clear done.
  - ERR: err=1. Any further bytes are left unaccepted (rx_ready=0). On start, go to HDR_LO and clear err.
- Output rules:
  - busy=1 in HDR_LO, HDR_HI, CHECK, DATA and WRITE.
  - cpu_hold=busy.
  - mem_we is 1 only in WRITE.
- Latency: mem_we asserts on the cycle after the 4th byte of a word is accepted. Peak throughput is one byte per cycle, with one bubble cycle per word.
- Boundaries:
  - rx_valid held high across WRITE: the byte stays pending, is not lost, and is accepted in the following DATA cycle.
  - n_words==DEPTH: addresses 0..DEPTH-1 are written, with no wrap.
  - Extra bytes after DONE are not consumed.
  - start asserted together with an accepted byte is a don't-care, since start is only sampled in IDLE, DONE and ERR.

Decomposition:
- Shared package: state enum (IDLE, HDR_LO, HDR_HI, CHECK, DATA, WRITE, DONE, ERR) and the header width constant (16).
- Single flat module; the byte assembler is too small to justify a sub-module.
- Instantiated beside inst_mem, with cpu_hold gating the core's PC register.

Test Plan:
- Reset, then idle 10 cycles: all outputs 0, no mem_we.
- start, then bytes 02 00 | 13 00 00 00 | 93 00 10 00: expect two writes, addr0=0x00000013 and addr1=0x00100093. After the last write, done=1 and cpu_hold=0.
- Header 00 00: goes to DONE with no mem_we; done=1 within 3 cycles of the second header byte.
- Header 01 01 (257 > DEPTH): err=1, no writes, rx_ready stays 0. A new start followed by a valid 1-word load clears err and sets done.
- rx_valid held continuously at 1 for a 3-word load: exactly 3 mem_we pulses at addr 0,1,2, no byte dropped or duplicated, and rx_ready=0 on each WRITE cycle.
- rst asserted after 2 data bytes: all outputs 0 next cycle, no mem_we; a subsequent full load succeeds.
